// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl_if
//  Description : Control/status bundle between the multi-cycle controller
//                and the MIPS-subset datapath with its shared memory port.
//  Revision    : 1.0  initial release
// ============================================================================
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    // Datapath -> controller
    logic [5:0]       opCode;
    logic [5:0]       fnCode;
    logic             zero;
    logic             mem_ready;
    logic             int_req;

    // Controller -> datapath
    logic             PCWrite;
    logic             PCWriteCond;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic             Mem2Reg;
    logic             RegDst;
    logic             RegWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [2:0]       op;
    logic [1:0]       PCSource;
    logic             illegal;
    logic             retired;
    logic [CNT_W-1:0] instr_count;
    logic [3:0]       state;

    // The controller side issues the control word.
    modport master (
        input  opCode, fnCode, zero, mem_ready, int_req,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               Mem2Reg, RegDst, RegWrite, ALUSrcA, ALUSrcB, op, PCSource,
               illegal, retired, instr_count, state
    );

    modport slave (
        output opCode, fnCode, zero, mem_ready, int_req,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               Mem2Reg, RegDst, RegWrite, ALUSrcA, ALUSrcB, op, PCSource,
               illegal, retired, instr_count, state
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Multi-cycle control FSM for the MIPS-subset datapath with a
//                shared memory port, ready handshake, interrupt entry and a
//                retired-instruction counter.
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int MEM_LAT = 0,
    parameter int CNT_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    multicycle_ctrl_if.master   bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_IRQ    = 4'd12
    } state_t;

    localparam logic [3:0] c_mem_lat = 4'(MEM_LAT);
    localparam logic [2:0] c_op_add  = 3'b010;
    localparam logic [2:0] c_op_sub  = 3'b110;
    localparam logic [2:0] c_op_and  = 3'b000;
    localparam logic [2:0] c_op_or   = 3'b001;
    localparam logic [2:0] c_op_slt  = 3'b111;

    state_t           state_q, state_d;
    logic [3:0]       wait_q, wait_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic w_done;
    logic w_mem_state;
    logic w_rfn_ok;
    logic w_retire;

    assign w_done      = bus.mem_ready && (wait_q == c_mem_lat);
    assign w_mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                         (state_q == S_MEMWR);
    assign w_rfn_ok    = (bus.fnCode == 6'd32) || (bus.fnCode == 6'd34) ||
                         (bus.fnCode == 6'd36) || (bus.fnCode == 6'd37) ||
                         (bus.fnCode == 6'd42);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IRQ;
            wait_q  <= 4'd0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        w_retire        = 1'b0;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.Mem2Reg     = 1'b0;
        bus.RegDst      = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.op          = c_op_add;
        bus.PCSource    = 2'b00;
        bus.illegal     = 1'b0;

        case (state_q)
            S_IRQ: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'b11;
                state_d      = S_FETCH;
            end
            S_FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                if (w_done) begin
                    bus.IRWrite = 1'b1;
                    bus.PCWrite = 1'b1;
                    state_d     = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is precomputed here while the opcode decodes.
                bus.ALUSrcB = 2'b11;
                case (bus.opCode)
                    6'd35, 6'd43: state_d = S_MEMADR;
                    6'd4:         state_d = S_BRANCH;
                    6'd2:         state_d = S_JUMP;
                    6'd8:         state_d = S_ADDIEX;
                    6'd0: begin
                        if (w_rfn_ok) begin
                            state_d = S_EXEC;
                        end else begin
                            bus.illegal = 1'b1;
                            w_retire    = 1'b1;
                        end
                    end
                    default: begin
                        bus.illegal = 1'b1;
                        w_retire    = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                state_d     = (bus.opCode == 6'd43) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
                if (w_done) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                bus.RegWrite = 1'b1;
                bus.Mem2Reg  = 1'b1;
                w_retire     = 1'b1;
            end
            S_MEMWR: begin
                bus.IorD     = 1'b1;
                bus.MemWrite = 1'b1;
                w_retire     = w_done;
            end
            S_EXEC: begin
                bus.ALUSrcA = 1'b1;
                case (bus.fnCode)
                    6'd34:   bus.op = c_op_sub;
                    6'd36:   bus.op = c_op_and;
                    6'd37:   bus.op = c_op_or;
                    6'd42:   bus.op = c_op_slt;
                    default: bus.op = c_op_add;
                endcase
                state_d = S_RWB;
            end
            S_RWB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 1'b1;
                w_retire     = 1'b1;
            end
            S_BRANCH: begin
                bus.ALUSrcA     = 1'b1;
                bus.op          = c_op_sub;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 2'b01;
                w_retire        = 1'b1;
            end
            S_JUMP: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'b10;
                w_retire     = 1'b1;
            end
            S_ADDIEX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                state_d     = S_ADDIWB;
            end
            S_ADDIWB: begin
                bus.RegWrite = 1'b1;
                w_retire     = 1'b1;
            end
            default: state_d = S_IRQ;
        endcase

        // Interrupts are only taken between instructions.
        if (w_retire) begin
            state_d = bus.int_req ? S_IRQ : S_FETCH;
        end
    end

    always_comb begin
        count_d = count_q + CNT_W'(w_retire);
        if (state_d != state_q) begin
            wait_d = 4'd0;
        end else if (w_mem_state && (wait_q != c_mem_lat)) begin
            wait_d = wait_q + 4'd1;
        end else begin
            wait_d = wait_q;
        end
    end

    assign bus.retired     = w_retire;
    assign bus.instr_count = count_q;
    assign bus.state       = state_q;

endmodule
`default_nettype wire
